// File: rtl/data_mem_responder.sv
// Load/store responder: valid/ready request and response channels,
// configurable wait states, little-endian byte RAM with load extension.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_type,
  input  logic                  req_sign_ext,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int  CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int  LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam bit  ZW   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    wr_q;
  logic [1:0]              type_q;
  logic                    sext_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic [7:0]              mem [2**ADDR_WIDTH];

  logic                    unused_addr;
  assign unused_addr = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];

  logic fire, req_err, acc;
  assign fire = req_valid && (state_q == IDLE);
  assign req_err = (req_type == 2'b11) ||
                   (req_type == 2'b01 && req_addr[0]) ||
                   (req_type == 2'b10 && req_addr[1:0] != 2'b00);

  // With zero wait states the access uses the live request on edge k.
  logic                  a_wr, a_sext;
  logic [1:0]            a_type;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  assign a_wr    = ZW ? req_write    : wr_q;
  assign a_sext  = ZW ? req_sign_ext : sext_q;
  assign a_type  = ZW ? req_type     : type_q;
  assign a_addr  = ZW ? req_addr[ADDR_WIDTH-1:0] : addr_q;
  assign a_wdata = ZW ? req_wdata    : wdata_q;

  assign acc = ZW ? (fire && !req_err)
                  : (state_q == BUSY && cnt_q == CW'(LAST));

  logic [7:0]            rb [4];
  logic [7:0]            lane_wd [4];
  logic [3:0]            lane_we;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_d;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rb[i]      = mem[{a_addr[ADDR_WIDTH-1:2], 2'(i)}];
      lane_we[i] = 1'b0;
      lane_wd[i] = a_wdata[7:0];
      case (a_type)
        2'b00: lane_we[i] = (a_addr[1:0] == 2'(i));
        2'b01: begin
          lane_we[i] = (a_addr[1] == i[1]);
          lane_wd[i] = i[0] ? a_wdata[15:8] : a_wdata[7:0];
        end
        default: begin
          lane_we[i] = 1'b1;
          lane_wd[i] = a_wdata[8*i +: 8];
        end
      endcase
    end
  end

  always_comb begin
    byte_sel = rb[a_addr[1:0]];
    half_sel = a_addr[1] ? {rb[3], rb[2]} : {rb[1], rb[0]};
    case (a_type)
      2'b00:   load_d = {{(DATA_WIDTH-8){a_sext & byte_sel[7]}}, byte_sel};
      2'b01:   load_d = {{(DATA_WIDTH-16){a_sext & half_sel[15]}}, half_sel};
      default: load_d = {rb[3], rb[2], rb[1], rb[0]};
    endcase
  end

  // A store caught by reset before its access edge never reaches the RAM.
  always_ff @(posedge clk) begin
    if (acc && a_wr && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we[i]) mem[{a_addr[ADDR_WIDTH-1:2], 2'(i)}] <= lane_wd[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      type_q       <= 2'b00;
      sext_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          wr_q        <= req_write;
          type_q      <= req_type;
          sext_q      <= req_sign_ext;
          addr_q      <= req_addr[ADDR_WIDTH-1:0];
          wdata_q     <= req_wdata;
          req_ready_q <= 1'b0;
          cnt_q       <= '0;
          if (req_err) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            err_q        <= 1'b1;
            rdata_q      <= '0;
          end else if (ZW) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= req_write ? '0 : load_d;
          end else begin
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == CW'(LAST)) begin
            state_q      <= RESP;
            cnt_q        <= '0;
            resp_valid_q <= 1'b1;
            rdata_q      <= wr_q ? '0 : load_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: if (resp_ready) begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          rdata_q      <= '0;
          err_q        <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed vector bench for data_mem_responder with WAIT_CYCLES=2.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_type = 2'b00;
  logic        req_sign_ext = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_type(req_type),
    .req_sign_ext(req_sign_ext), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata,      32'd0);
    chk({tag, "_resp_err"},   32'(resp_err),   32'd0);
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [1:0] ty,
                        input logic sx, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata,
                        output logic err, output int lat);
    @(negedge clk);
    chk({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_type = ty;
    req_sign_ext = sx; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF;
    req_wdata = 32'h5555_5555;
    chk({tag, "_ready_low"}, 32'(req_ready), 32'd0);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (resp_valid) break;
      lat++;
    end
    rdata = resp_rdata;
    err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk({tag, "_valid_clr"}, 32'(resp_valid), 32'd0);
    chk({tag, "_rdata_clr"}, resp_rdata, 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  ty;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [31:0] rd, hold;
    logic        er;
    int          lt;
    string       tg;

    tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h200,      32'h80FF7F01, 32'h0,        1'b0, 2};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h200,      32'h0,        32'h80FF7F01, 1'b0, 2};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h203,      32'h0,        32'hFFFFFF80, 1'b0, 2};
    tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h203,      32'h0,        32'h00000080, 1'b0, 2};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 32'h202,      32'h0,        32'hFFFF80FF, 1'b0, 2};
    tbl[5]  = '{1'b0, 2'b01, 1'b0, 32'h200,      32'h0,        32'h00007F01, 1'b0, 2};
    tbl[6]  = '{1'b1, 2'b00, 1'b0, 32'h201,      32'h123456AB, 32'h0,        1'b0, 2};
    tbl[7]  = '{1'b0, 2'b10, 1'b0, 32'h200,      32'h0,        32'h80FFAB01, 1'b0, 2};
    tbl[8]  = '{1'b0, 2'b10, 1'b0, 32'h00010200, 32'h0,        32'h80FFAB01, 1'b0, 2};
    tbl[9]  = '{1'b1, 2'b10, 1'b0, 32'h100,      32'h11223344, 32'h0,        1'b0, 2};
    tbl[10] = '{1'b1, 2'b10, 1'b0, 32'h102,      32'hDEADBEEF, 32'h0,        1'b1, 0};
    tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h100,      32'h0,        32'h11223344, 1'b0, 2};
    tbl[12] = '{1'b0, 2'b11, 1'b0, 32'h100,      32'h0,        32'h0,        1'b1, 0};
    tbl[13] = '{1'b0, 2'b01, 1'b1, 32'h101,      32'h0,        32'h0,        1'b1, 0};
    tbl[14] = '{1'b1, 2'b01, 1'b0, 32'h102,      32'hBBBBCAFE, 32'h0,        1'b0, 2};
    tbl[15] = '{1'b0, 2'b10, 1'b0, 32'h100,      32'h0,        32'hCAFE3344, 1'b0, 2};
    tbl[16] = '{1'b0, 2'b00, 1'b1, 32'h202,      32'h0,        32'hFFFFFFFF, 1'b0, 2};
    tbl[17] = '{1'b1, 2'b10, 1'b0, 32'h300,      32'hA5A5A5A5, 32'h0,        1'b0, 2};
    tbl[18] = '{1'b0, 2'b01, 1'b1, 32'h302,      32'h0,        32'hFFFFA5A5, 1'b0, 2};

    // Asynchronous reset asserted between clock edges.
    #12 rst = 1'b1;
    #1 chk_reset_outs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      tg = $sformatf("v%0d", i);
      do_req(tg, tbl[i].wr, tbl[i].ty, tbl[i].sx, tbl[i].addr,
             tbl[i].wd, rd, er, lt);
      chk({tg, "_rdata"}, rd, tbl[i].exp);
      chk({tg, "_err"}, 32'(er), 32'(tbl[i].err));
      chk({tg, "_lat"}, 32'(lt), 32'(tbl[i].lat));
    end

    // Backpressure: response held while requests are ignored.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_type = 2'b10;
    req_sign_ext = 1'b0; req_addr = 32'h200;
    @(posedge clk);
    #1;
    req_addr = 32'h100;
    req_write = 1'b1;
    lt = 0;
    while (lt < 20) begin
      @(negedge clk);
      if (resp_valid) break;
      lt++;
    end
    chk("bp_lat", 32'(lt), 32'd2);
    hold = resp_rdata;
    chk("bp_rdata", hold, 32'h80FFAB01);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", c), 32'(resp_valid), 32'd1);
      chk($sformatf("bp_hold%0d", c), resp_rdata, 32'h80FFAB01);
      chk($sformatf("bp_ready%0d", c), 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    req_write = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("bp_consumed", 32'(resp_valid), 32'd0);
    do_req("bp_after", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lt);
    chk("bp_after_rdata", rd, 32'hCAFE3344);

    // Reset while a store is still waiting: store must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_type = 2'b10;
    req_addr = 32'h300; req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk_reset_outs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_req("midrst_ld", 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, rd, er, lt);
    chk("midrst_rdata", rd, 32'hA5A5A5A5);
    chk("midrst_err", 32'(er), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for load/store requests issued by the core's memory stage.
- Accepts one request at a time over a valid/ready handshake and models a configurable number of wait states.
- Performs byte, half-word or word access on a little-endian internal RAM, with load sign/zero extension.
- Returns the result over a valid/ready response channel, so the core can be stalled on multi-cycle data memory.

Parameters:
- DATA_WIDTH, 32, data and address bus width.
- ADDR_WIDTH, 16, number of byte-address bits decoded; RAM holds 2^ADDR_WIDTH bytes.
- WAIT_CYCLES, 2, wait-state cycles between request acceptance and memory access; 0 is legal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_type  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- req_sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  DATA_WIDTH  byte address; only bits [ADDR_WIDTH-1:0] used.
- req_wdata  input  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  response present.
- resp_ready  input  1  requester consumes the response.
- resp_rdata  output  DATA_WIDTH  load result; 0 for stores and errors.
- resp_err  output  1  request rejected as misaligned or reserved type.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - state IDLE, wait counter 0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - RAM contents are not cleared and are undefined at power-up.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - Handshake fires on a rising edge with req_valid&&req_ready; call this edge k.
  - The request is captured into internal registers.
  - Later changes on req_* inputs are ignored until the next IDLE.
- Error check at acceptance:
  - type 11, half with addr[0]=1, or word with addr[1:0]!=0 is an error.
  - Error request: goes directly to RESP with resp_err=1 and resp_rdata=0.
  - No RAM access and no wait states for an error request.
- Valid request:
  - If WAIT_CYCLES=0: RAM access on edge k, then RESP.
  - Otherwise: BUSY; counter increments each cycle.
  - On the edge where the counter reaches WAIT_CYCLES-1: RAM access, then RESP.
  - resp_valid is first high in the cycle after edge k+WAIT_CYCLES.
- Store:
  - Byte writes lane addr[1:0]; half writes lanes {addr[1],0} and {addr[1],1}; word writes all four lanes.
  - No other bytes are modified.
- Load:
  - Byte selected by addr[1:0]; half selected by addr[1].
  - Extended to 32 bits per req_sign_ext; word is passed unchanged.
  - resp_rdata is registered at the access edge.
- Addresses wrap modulo 2^ADDR_WIDTH; upper address bits are ignored and raise no error.
- RESP:
  - resp_valid=1 and req_ready=0.
  - resp_rdata/resp_err are held stable until resp_valid&&resp_ready on an edge.
  - On that edge: resp_valid=0, resp_rdata=0, resp_err=0, state IDLE.
- A new request is not accepted in the same cycle as response consumption.
- Minimum back-to-back spacing is one IDLE cycle.
- Reset mid-operation: asserting rst in BUSY or RESP returns to IDLE immediately with reset output values.
  - A store still in BUSY is dropped and the RAM is unchanged.
  - A store already committed at its access edge remains.
- req_valid low in IDLE: no state change. resp_ready is ignored outside RESP.

Test Plan:
All scenarios use WAIT_CYCLES=2.
- Reset: assert rst asynchronously mid-cycle -> outputs immediately req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Word store 0x80FF7F01 to 0x200, accepted at edge k:
  - req_ready=0 after k; resp_valid=1 after edge k+2 with resp_err=0, resp_rdata=0.
  - Word load from 0x200 returns 0x80FF7F01.
- Loads from the word at 0x200:
  - byte 0x203 signed -> 0xFFFFFF80; unsigned -> 0x00000080.
  - half 0x202 signed -> 0xFFFF80FF; half 0x200 unsigned -> 0x00007F01.
- Byte store 0x000000AB to 0x201, then word load 0x200 -> 0x80FFAB01.
  - Wrap check: word load from 0x00010200 returns the same value.
- Misaligned word store to 0x102:
  - resp_valid=1 after edge k with resp_err=1, resp_rdata=0.
  - A following word load of 0x100 shows contents unchanged.
- Backpressure and reset:
  - Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/resp_rdata stable, req_valid ignored.
  - Assert rst one cycle after accepting a word store 0x12345678 to 0x300 -> state IDLE; load of 0x300 returns the prior value.
